// File: rtl/riscv_core_pipe_pkg.sv
// Shared constants and types for the elastic pipeline register chain.
package riscv_core_pipe_pkg;

  localparam int W_PIPE_BUS_DEF = 32;
  localparam int N_STAGES_DEF   = 2;

  // Counter must hold 0..2*n_stages inclusive (main + skid per stage).
  function automatic int clog2_cnt(input int n_stages);
    return $clog2(2 * n_stages + 1);
  endfunction

  typedef struct packed {
    logic                      valid;
    logic [W_PIPE_BUS_DEF-1:0] data;
  } pipe_slot_t;

endpackage

// File: rtl/riscv_core_pipe_skid.sv
// One skid-buffered elastic stage: main register drives downstream, skid absorbs one beat of backpressure.
// Build option RISCV_CORE_PIPE_ZERO_DATA_EN: data registers reset/clear/zero when they go empty.
module riscv_core_pipe_skid
  import riscv_core_pipe_pkg::*;
#(
  parameter int W_PIPE_BUS = W_PIPE_BUS_DEF
) (
  input  logic                  i_pipe_clk,
  input  logic                  i_pipe_rst_n,
  input  logic                  i_pipe_clr,
  input  logic                  i_up_valid,
  output logic                  o_up_ready,
  input  logic [W_PIPE_BUS-1:0] i_up_data,
  output logic                  o_dn_valid,
  input  logic                  i_dn_ready,
  output logic [W_PIPE_BUS-1:0] o_dn_data
);

  logic                  m_v_q, m_v_d, s_v_q, s_v_d;
  logic [W_PIPE_BUS-1:0] m_d_q, m_d_d, s_d_q, s_d_d;
  logic                  up_acc, dn_take;

  assign up_acc     = i_up_valid && !s_v_q;
  assign dn_take    = m_v_q && i_dn_ready;
  assign o_up_ready = !s_v_q;
  assign o_dn_valid = m_v_q;
  assign o_dn_data  = m_d_q;

  always_comb begin
    m_v_d = m_v_q;
    s_v_d = s_v_q;
    m_d_d = m_d_q;
    s_d_d = s_d_q;
    if (i_pipe_clr) begin
      m_v_d = 1'b0;
      s_v_d = 1'b0;
`ifdef RISCV_CORE_PIPE_ZERO_DATA_EN
      m_d_d = '0;
      s_d_d = '0;
`endif
    end else if (dn_take) begin
      // Skid full implies up_acc is low, so the refill comes only from the skid.
      if (s_v_q) begin
        m_d_d = s_d_q;
        s_v_d = 1'b0;
`ifdef RISCV_CORE_PIPE_ZERO_DATA_EN
        s_d_d = '0;
`endif
      end else if (up_acc) begin
        m_d_d = i_up_data;
      end else begin
        m_v_d = 1'b0;
`ifdef RISCV_CORE_PIPE_ZERO_DATA_EN
        m_d_d = '0;
`endif
      end
    end else if (!m_v_q && up_acc) begin
      m_v_d = 1'b1;
      m_d_d = i_up_data;
    end else if (m_v_q && up_acc) begin
      s_v_d = 1'b1;
      s_d_d = i_up_data;
    end
  end

  always_ff @(posedge i_pipe_clk or negedge i_pipe_rst_n) begin
    if (!i_pipe_rst_n) begin
      m_v_q <= 1'b0;
      s_v_q <= 1'b0;
    end else begin
      m_v_q <= m_v_d;
      s_v_q <= s_v_d;
    end
  end

`ifdef RISCV_CORE_PIPE_ZERO_DATA_EN
  always_ff @(posedge i_pipe_clk or negedge i_pipe_rst_n) begin
    if (!i_pipe_rst_n) begin
      m_d_q <= '0;
      s_d_q <= '0;
    end else begin
      m_d_q <= m_d_d;
      s_d_q <= s_d_d;
    end
  end
`else
  always_ff @(posedge i_pipe_clk) begin
    m_d_q <= m_d_d;
    s_d_q <= s_d_d;
  end
`endif

endmodule

// File: rtl/riscv_core_pipe_elastic.sv
// Chain of N_STAGES skid stages with flush and registered occupancy count; full throughput, registered ready.
// Build option RISCV_CORE_PIPE_ZERO_DATA_EN zeroes payload registers whenever they hold no valid entry.
module riscv_core_pipe_elastic
  import riscv_core_pipe_pkg::*;
#(
  parameter  int W_PIPE_BUS = W_PIPE_BUS_DEF,
  parameter  int N_STAGES   = N_STAGES_DEF,
  localparam int W_CNT      = clog2_cnt(N_STAGES)
) (
  input  logic                  i_pipe_clk,
  input  logic                  i_pipe_rst_n,
  input  logic                  i_pipe_clr,
  input  logic                  i_pipe_valid,
  output logic                  o_pipe_ready,
  input  logic [W_PIPE_BUS-1:0] i_pipe_in,
  output logic                  o_pipe_valid,
  input  logic                  i_pipe_ready,
  output logic [W_PIPE_BUS-1:0] o_pipe_out,
  output logic [W_CNT-1:0]      o_pipe_count
);

  // Index g is the interface feeding stage g; index N_STAGES is the chain output.
  logic [N_STAGES:0]                 chain_v, chain_rdy;
  logic [N_STAGES:0][W_PIPE_BUS-1:0] chain_d;

  assign chain_v[0]          = i_pipe_valid;
  assign chain_d[0]          = i_pipe_in;
  assign o_pipe_ready        = chain_rdy[0];
  assign chain_rdy[N_STAGES] = i_pipe_ready;
  assign o_pipe_valid        = chain_v[N_STAGES];
  assign o_pipe_out          = chain_d[N_STAGES];

  for (genvar g = 0; g < N_STAGES; g++) begin : g_stage
    riscv_core_pipe_skid #(
      .W_PIPE_BUS (W_PIPE_BUS)
    ) u_skid (
      .i_pipe_clk   (i_pipe_clk),
      .i_pipe_rst_n (i_pipe_rst_n),
      .i_pipe_clr   (i_pipe_clr),
      .i_up_valid   (chain_v[g]),
      .o_up_ready   (chain_rdy[g]),
      .i_up_data    (chain_d[g]),
      .o_dn_valid   (chain_v[g+1]),
      .i_dn_ready   (chain_rdy[g+1]),
      .o_dn_data    (chain_d[g+1])
    );
  end

  logic             up_acc, dn_take;
  logic [W_CNT-1:0] count_q, count_d;

  assign up_acc       = i_pipe_valid && o_pipe_ready;
  assign dn_take      = o_pipe_valid && i_pipe_ready;
  assign o_pipe_count = count_q;

  always_comb begin
    count_d = count_q;
    if (i_pipe_clr) begin
      count_d = '0;
    end else if (up_acc && !dn_take) begin
      count_d = count_q + W_CNT'(1);
    end else if (!up_acc && dn_take) begin
      count_d = count_q - W_CNT'(1);
    end
  end

  always_ff @(posedge i_pipe_clk or negedge i_pipe_rst_n) begin
    if (!i_pipe_rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_riscv_core_pipe_elastic.sv
// Bench for riscv_core_pipe_elastic: directed scenarios on N_STAGES=2, random scoreboard run on N_STAGES=2/1/4.
module tb_riscv_core_pipe_elastic;
  import riscv_core_pipe_pkg::*;

  localparam int W = 32;
  localparam int NS [3] = '{2, 1, 4};

  logic         clk;
  logic         rst_n, clr, vin, rdy_in;
  logic [W-1:0] din;
  logic         ov [3];
  logic         ordy [3];
  logic [W-1:0] oo [3];
  logic [clog2_cnt(2)-1:0] c2;
  logic [clog2_cnt(1)-1:0] c1;
  logic [clog2_cnt(4)-1:0] c4;

  int n_chk  = 0;
  int n_pass = 0;

  pipe_slot_t sb [3][$];

  riscv_core_pipe_elastic #(.W_PIPE_BUS(W), .N_STAGES(2)) u_dut (
    .i_pipe_clk(clk), .i_pipe_rst_n(rst_n), .i_pipe_clr(clr),
    .i_pipe_valid(vin), .o_pipe_ready(ordy[0]), .i_pipe_in(din),
    .o_pipe_valid(ov[0]), .i_pipe_ready(rdy_in), .o_pipe_out(oo[0]), .o_pipe_count(c2));

  riscv_core_pipe_elastic #(.W_PIPE_BUS(W), .N_STAGES(1)) u_dut1 (
    .i_pipe_clk(clk), .i_pipe_rst_n(rst_n), .i_pipe_clr(clr),
    .i_pipe_valid(vin), .o_pipe_ready(ordy[1]), .i_pipe_in(din),
    .o_pipe_valid(ov[1]), .i_pipe_ready(rdy_in), .o_pipe_out(oo[1]), .o_pipe_count(c1));

  riscv_core_pipe_elastic #(.W_PIPE_BUS(W), .N_STAGES(4)) u_dut4 (
    .i_pipe_clk(clk), .i_pipe_rst_n(rst_n), .i_pipe_clr(clr),
    .i_pipe_valid(vin), .o_pipe_ready(ordy[2]), .i_pipe_in(din),
    .o_pipe_valid(ov[2]), .i_pipe_ready(rdy_in), .o_pipe_out(oo[2]), .o_pipe_count(c4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cnt_of(input int k);
    case (k)
      0:       return int'(c2);
      1:       return int'(c1);
      default: return int'(c4);
    endcase
  endfunction

  // Leaves the caller just after a rising edge with inputs idle.
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; clr = 1'b0; vin = 1'b0; rdy_in = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic fill_three();
    rdy_in = 1'b0; vin = 1'b1; din = 32'h1;
    @(posedge clk); #1; din = 32'h2;
    @(posedge clk); #1; din = 32'h3;
    @(posedge clk); #1; vin = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; clr = 1'b0; vin = 1'b1; din = 32'hDEADBEEF; rdy_in = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++; if (ov[0] !== 1'b0) $display("FAIL rst_valid: got %b want 0", ov[0]); else n_pass++;
    n_chk++; if (ordy[0] !== 1'b1) $display("FAIL rst_ready: got %b want 1", ordy[0]); else n_pass++;
    n_chk++; if (c2 !== 3'd0) $display("FAIL rst_count: got %0d want 0", c2); else n_pass++;
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1; vin = 1'b0;
    @(negedge clk);
    n_chk++; if (ov[0] !== 1'b0) $display("FAIL rst_lat_early: got %b want 0", ov[0]); else n_pass++;
    n_chk++; if (c2 !== 3'd1) $display("FAIL rst_lat_count: got %0d want 1", c2); else n_pass++;
    @(negedge clk);
    n_chk++; if (ov[0] !== 1'b1) $display("FAIL rst_first_valid: got %b want 1", ov[0]); else n_pass++;
    n_chk++; if (oo[0] !== 32'hDEADBEEF) $display("FAIL rst_first_data: got %h want deadbeef", oo[0]); else n_pass++;
    @(negedge clk);
    n_chk++; if (c2 !== 3'd0) $display("FAIL rst_drain_count: got %0d want 0", c2); else n_pass++;
  endtask

  task automatic test_stream();
    int sent = 0, got = 0, bubbles = 0;
    bit seen = 0, hs;
    do_reset();
    rdy_in = 1'b1; vin = 1'b1; din = 32'h1;
    for (int cyc = 0; cyc < 40 && got < 16; cyc++) begin
      @(negedge clk);
      hs = vin && ordy[0];
      if (vin) begin
        n_chk++; if (ordy[0] !== 1'b1) $display("FAIL stream_ready: got %b want 1", ordy[0]); else n_pass++;
      end
      if (ov[0]) begin
        seen = 1;
        n_chk++; if (oo[0] !== W'(got + 1)) $display("FAIL stream_data: got %h want %h", oo[0], got + 1); else n_pass++;
        if (oo[0] !== 32'h10) begin
          n_chk++; if (c2 !== 3'd2) $display("FAIL stream_count: got %0d want 2", c2); else n_pass++;
        end
        got++;
      end else if (seen) begin
        bubbles++;
      end
      @(posedge clk); #1;
      if (hs) sent++;
      if (sent < 16) din = W'(sent + 1); else vin = 1'b0;
    end
    n_chk++; if (got !== 16) $display("FAIL stream_total: got %0d want 16", got); else n_pass++;
    n_chk++; if (bubbles !== 0) $display("FAIL stream_bubbles: got %0d want 0", bubbles); else n_pass++;
  endtask

  task automatic test_backpressure();
    int acc = 0, got = 0;
    bit hs;
    do_reset();
    rdy_in = 1'b0; vin = 1'b1; din = 32'hA0;
    repeat (8) begin
      @(negedge clk);
      n_chk++; if (ordy[0] !== (acc < 4)) $display("FAIL bp_ready: got %b want %b after %0d accepts", ordy[0], acc < 4, acc); else n_pass++;
      if (vin && ordy[0]) acc++;
      @(posedge clk); #1; din = W'(32'hA0 + acc);
    end
    @(negedge clk);
    n_chk++; if (acc !== 4) $display("FAIL bp_accepted: got %0d want 4", acc); else n_pass++;
    n_chk++; if (c2 !== 3'd4) $display("FAIL bp_count: got %0d want 4", c2); else n_pass++;
    n_chk++; if (oo[0] !== 32'hA0 || ov[0] !== 1'b1) $display("FAIL bp_head: got %b/%h want 1/a0", ov[0], oo[0]); else n_pass++;
    @(posedge clk); #1; rdy_in = 1'b1;
    for (int cyc = 0; cyc < 30 && got < 6; cyc++) begin
      @(negedge clk);
      hs = vin && ordy[0];
      if (ov[0]) begin
        n_chk++; if (oo[0] !== W'(32'hA0 + got)) $display("FAIL bp_order: got %h want %h", oo[0], 32'hA0 + got); else n_pass++;
        got++;
      end
      @(posedge clk); #1;
      if (hs) acc++;
      if (acc < 6) din = W'(32'hA0 + acc); else vin = 1'b0;
    end
    n_chk++; if (got !== 6) $display("FAIL bp_drain: got %0d want 6", got); else n_pass++;
  endtask

  task automatic test_flush();
    int leaked = 0;
    do_reset();
    fill_three();
    @(negedge clk);
    n_chk++; if (c2 !== 3'd3) $display("FAIL flush_fill: got %0d want 3", c2); else n_pass++;
    @(posedge clk); #1;
    clr = 1'b1; vin = 1'b1; din = 32'h55; rdy_in = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; vin = 1'b0;
    @(negedge clk);
    n_chk++; if (c2 !== 3'd0) $display("FAIL flush_count: got %0d want 0", c2); else n_pass++;
    n_chk++; if (ov[0] !== 1'b0) $display("FAIL flush_valid: got %b want 0", ov[0]); else n_pass++;
    n_chk++; if (ordy[0] !== 1'b1) $display("FAIL flush_ready: got %b want 1", ordy[0]); else n_pass++;
`ifdef RISCV_CORE_PIPE_ZERO_DATA_EN
    n_chk++; if (oo[0] !== 32'h0) $display("FAIL flush_zero: got %h want 0", oo[0]); else n_pass++;
`endif
    repeat (6) begin
      @(negedge clk);
      if (ov[0]) leaked++;
    end
    n_chk++; if (leaked !== 0) $display("FAIL flush_leak: got %0d valid cycles want 0", leaked); else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    fill_three();
    @(negedge clk);
    n_chk++; if (c2 !== 3'd3) $display("FAIL arst_fill: got %0d want 3", c2); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (ov[0] !== 1'b0) $display("FAIL arst_valid: got %b want 0", ov[0]); else n_pass++;
    n_chk++; if (c2 !== 3'd0) $display("FAIL arst_count: got %0d want 0", c2); else n_pass++;
    n_chk++; if (ordy[0] !== 1'b1) $display("FAIL arst_ready: got %b want 1", ordy[0]); else n_pass++;
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic test_random();
    int  pv = 3, pr = 2;
    bit  take [3];
    bit  acc [3];
    bit  r_before;
    pipe_slot_t slot;
    do_reset();
    for (int k = 0; k < 3; k++) sb[k].delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (cyc % 500 == 0) begin
        pv = $urandom_range(1, 4);
        pr = $urandom_range(1, 4);
      end
      vin    = ($urandom_range(1, 4) <= pv);
      rdy_in = ($urandom_range(1, 4) <= pr);
      din    = $urandom;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        n_chk++; if (cnt_of(k) !== sb[k].size()) $display("FAIL rnd_count[N=%0d]: got %0d want %0d", NS[k], cnt_of(k), sb[k].size()); else n_pass++;
        if (ov[k]) begin
          n_chk++;
          if (sb[k].size() == 0) $display("FAIL rnd_spurious[N=%0d]: got valid %h want empty", NS[k], oo[k]);
          else if (oo[k] !== sb[k][0].data) $display("FAIL rnd_data[N=%0d]: got %h want %h", NS[k], oo[k], sb[k][0].data);
          else n_pass++;
        end
      end
      for (int k = 0; k < 3; k++) begin
        r_before = ordy[k];
        rdy_in = ~rdy_in; #1;
        n_chk++; if (ordy[k] !== r_before) $display("FAIL rnd_ready_comb[N=%0d]: got %b want %b", NS[k], ordy[k], r_before); else n_pass++;
        rdy_in = ~rdy_in; #0;
      end
      for (int k = 0; k < 3; k++) begin
        take[k] = ov[k] && rdy_in;
        acc[k]  = vin && ordy[k];
        if (take[k] && sb[k].size() > 0) void'(sb[k].pop_front());
        if (acc[k]) begin
          slot.valid = 1'b1;
          slot.data  = din;
          sb[k].push_back(slot);
        end
      end
      @(posedge clk); #1;
    end
    vin = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; vin = 1'b0; rdy_in = 1'b0; din = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/riscv_core_pipe_elastic.md
Name: riscv_core_pipe_elastic

Overview:
Parametrised elastic pipeline register chain. It replaces fixed enable/clear pipeline registers between RISC-V core stages wherever a valid/ready handshake is needed. It provides N_STAGES of skid-buffered registers, full throughput, registered ready per stage, synchronous flush and an occupancy count. It sits between core stages (e.g. IF→ID, EX→MEM) where backpressure or decoupling is required.

Parameters:
W_PIPE_BUS, 32, payload width in bits (>=1)
N_STAGES, 2, number of chained skid stages (>=1)
W_CNT, $clog2(2*N_STAGES+1), localparam, occupancy counter width (derived, not overridable)

Ports:
i_pipe_clk  in  1  clock, rising edge
i_pipe_rst_n  in  1  asynchronous, active-low reset
i_pipe_clr  in  1  synchronous flush, drops all held entries
i_pipe_valid  in  1  upstream payload valid
o_pipe_ready  out  1  chain can accept (stage 0 skid empty)
i_pipe_in  in  W_PIPE_BUS  upstream payload
o_pipe_valid  out  1  last stage main register valid
i_pipe_ready  in  1  downstream accepts
o_pipe_out  out  W_PIPE_BUS  last stage main register payload
o_pipe_count  out  W_CNT  valid entries held, 0..2*N_STAGES

Behaviour:
- Reset: i_pipe_rst_n is asynchronous and active-low; the clock is i_pipe_clk. Reset clears all main/skid valid bits immediately. Resulting outputs: o_pipe_valid=0, o_pipe_ready=1, o_pipe_count=0. Reset mid-transfer discards all contents; no partial state survives.
- A transfer occurs on a rising edge when valid && ready at that interface.
- Each stage holds a main register (m_v, m_d) and a skid register (s_v, s_d).
- Stage outputs are main: out_v=m_v, out_d=m_d. Stage ready = !s_v, a direct register output with no combinational path from downstream ready.
- Per-stage update on each edge, priority top-down:
  1. clr: m_v<=0, s_v<=0.
  2. Downstream takes main (m_v && dn_rdy):
     - s_v=1: main<=skid, s_v<=0.
     - else if input accepted: main<=input.
     - else: m_v<=0.
  3. Main empty (!m_v) and input accepted: main<=input (skid stays empty).
  4. Main held (m_v && !dn_rdy) and input accepted: skid<=input, s_v<=1.
- Input is accepted when up_v && !s_v.
- Ordering is strictly FIFO; no entry is ever duplicated or dropped except by clr/reset.
- Latency: with no backpressure, a payload accepted at edge k appears on o_pipe_out after edge k+N_STAGES-1 (visible in cycle k+N_STAGES-1 to k+N_STAGES).
- Throughput: 1 transfer/cycle sustained.
- Capacity is 2*N_STAGES entries. o_pipe_ready drops the cycle after stage 0 skid fills.
- Flush: a handshake at the upstream interface in the same cycle as i_pipe_clr counts as completed and its payload is discarded. A downstream handshake in the clr cycle is still valid (downstream consumed o_pipe_out). The cycle after clr: o_pipe_valid=0, o_pipe_ready=1, count=0.
- o_pipe_count is registered: it increments on an upstream accept, decrements on a downstream take, is unchanged on simultaneous accept and take, and is forced to 0 on clr. It never exceeds 2*N_STAGES and never underflows.
- When o_pipe_valid=0, o_pipe_out holds the last data (non-zeroed build); upstream/downstream must qualify with valid.

Optional Feature:
RISCV_CORE_PIPE_ZERO_DATA_EN
- Defined: all m_d/s_d reset asynchronously to 0, are cleared to 0 on i_pipe_clr, and a main register whose entry is consumed without refill is zeroed. o_pipe_out is therefore 0 whenever o_pipe_valid=0, matching the legacy cleared-register behaviour.
- Undefined: data registers have no reset and no clear (area/timing saving); only valid bits are reset or cleared. o_pipe_out is don't-care while invalid.

Decomposition:
- Package riscv_core_pipe_pkg holds:
  - default W_PIPE_BUS / N_STAGES constants
  - count-width function clog2_cnt
  - a typedef for a stage slot struct {valid, data} used by the bench scoreboard
- Sub-module riscv_core_pipe_skid: one stage (main+skid, up/down valid/ready, clr). The top instantiates N_STAGES in a generate chain and adds the occupancy counter.

Test Plan:
- Reset with i_pipe_valid=1, i_pipe_in=32'hDEADBEEF, i_pipe_ready=1 → during reset o_pipe_valid=0, o_pipe_ready=1, count=0; first accept after deassert appears on o_pipe_out 1 cycle later (N_STAGES=2).
- Stream 0x1..0x10 back-to-back, i_pipe_ready=1 → outputs 0x1..0x10 in order, one per cycle, count steady at 2, no bubbles.
- i_pipe_ready=0, push 0xA0..0xA5 continuously → exactly 4 accepted (0xA0..0xA3); o_pipe_ready=0 from the cycle after the 4th accept; count=4; releasing ready yields 0xA0..0xA3 in order, then 0xA4 is accepted.
- Fill to count=3, assert i_pipe_clr one cycle with i_pipe_valid=1 (0x55) → next cycle count=0, o_pipe_valid=0, 0x55 never emerges; with the macro defined, o_pipe_out=0.
- Random valid/ready (10k cycles, seeded) with N_STAGES=1 and 4 → scoreboard FIFO match, count equals scoreboard depth every cycle, o_pipe_ready never combinationally dependent on i_pipe_ready.
- Async reset asserted mid-stream between edges with count=3 → outputs go invalid immediately, count=0 without waiting for a clock edge.
